// File: rtl/bg_tile_renderer_if.sv
// Read-side memory bus of the background tile renderer: tile-map RAM and
// sprite-sheet ROM address/data pairs.
interface bg_tile_renderer_if;
   logic [15:0] bg_ram_addr;
   logic [31:0] bg_ram_data;
   logic [13:0] sheet_addr;
   logic [11:0] sheet_data;

   modport master (
      output bg_ram_addr,
      output sheet_addr,
      input  bg_ram_data,
      input  sheet_data
   );

   modport slave (
      input  bg_ram_addr,
      input  sheet_addr,
      output bg_ram_data,
      output sheet_data
   );
endinterface

// File: rtl/bg_tile_renderer.sv
// Background tile renderer: scan position + fine scroll -> tile-map read ->
// sprite-sheet read -> RGB444, with syncs/valid delayed by the same 4 cycles.
module bg_tile_renderer #(
   parameter int          TILE_COLS   = 40,
   parameter int          TILE_ROWS   = 30,
   parameter logic [11:0] TRANSPARENT = 12'hF0F,
   parameter logic [11:0] BG_COLOR    = 12'h6BF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                video_on,
   input  logic [9:0]          x,
   input  logic [9:0]          y,
   input  logic [3:0]          bg_x_offset,
   input  logic                hsync_in,
   input  logic                vsync_in,
   bg_tile_renderer_if.master  mem,
   output logic [11:0]         rgb,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                pix_valid
);

   // Syncs travel active-high internally so a cleared pipeline means "no sync".
   typedef struct packed {
      logic video_on;
      logic hsync;
      logic vsync;
      logic oor;
   } side_t;

   localparam logic [6:0] COLS7 = 7'(TILE_COLS);
   localparam logic [9:0] Y_END = 10'(TILE_ROWS * 16);

   // Stage A combinational address generation
   logic [10:0] sx;
   logic [6:0]  col_raw;
   logic [6:0]  col;
   logic [5:0]  row;
   logic        oor;
   logic [15:0] map_addr;
   side_t       side_in;

   // NOTE: every always_comb output gets a value before any branch, so no latch can form.
   always_comb begin
      sx       = {1'b0, x} + {7'b0, bg_x_offset};
      col_raw  = sx[10:4];
      col      = (col_raw >= COLS7) ? col_raw - COLS7 : col_raw;
      row      = y[9:4];
      oor      = (y >= Y_END);
      map_addr = oor ? 16'd0 : 16'(row) * 16'(TILE_COLS) + 16'(col);
      side_in  = '{video_on: video_on, hsync: ~hsync_in, vsync: ~vsync_in, oor: oor};
   end

   logic [3:0] px_a, py_a, px_b, py_b;
   side_t      side_a, side_b, side_c, side_d;
   logic       en_c, en_d;

   // Stage B attribute decode
   logic [8:0] attr;
   logic [3:0] px_f, py_f;
   logic       unused_attr_hi;

   assign attr           = mem.bg_ram_data[8:0];
   assign unused_attr_hi = ^mem.bg_ram_data[31:9];
   assign px_f           = attr[6] ? ~px_b : px_b;
   assign py_f           = attr[7] ? ~py_b : py_b;

   // Stage C colour selection
   logic [11:0] rgb_next;

   always_comb begin
      rgb_next = mem.sheet_data;
      if (!side_d.video_on || side_d.oor)
         rgb_next = 12'h000;
      else if (!en_d || mem.sheet_data == TRANSPARENT)
         rgb_next = BG_COLOR;
   end

   // NOTE: non-blocking assignments so every stage samples the previous stage's old value on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem.bg_ram_addr <= 16'd0;
         px_a            <= 4'd0;
         py_a            <= 4'd0;
         side_a          <= '0;
         px_b            <= 4'd0;
         py_b            <= 4'd0;
         side_b          <= '0;
         mem.sheet_addr  <= 14'd0;
         en_c            <= 1'b0;
         side_c          <= '0;
         en_d            <= 1'b0;
         side_d          <= '0;
         rgb             <= 12'h000;
         pix_valid       <= 1'b0;
         hsync_out       <= 1'b1;
         vsync_out       <= 1'b1;
      end else begin
         // edge n: tile-map address issue
         mem.bg_ram_addr <= map_addr;
         px_a            <= sx[3:0];
         py_a            <= y[3:0];
         side_a          <= side_in;
         // edge n+1: wait for tile-map read
         px_b            <= px_a;
         py_b            <= py_a;
         side_b          <= side_a;
         // edge n+2: sheet address issue
         mem.sheet_addr  <= {attr[5:3], py_f, attr[2:0], px_f};
         en_c            <= attr[8];
         side_c          <= side_b;
         // edge n+3: wait for sheet read
         en_d            <= en_c;
         side_d          <= side_c;
         // edge n+4: pixel out
         rgb             <= rgb_next;
         pix_valid       <= side_d.video_on;
         hsync_out       <= ~side_d.hsync;
         vsync_out       <= ~side_d.vsync;
      end
   end

endmodule

// File: tb/tb_bg_tile_renderer.sv
// Directed self-checking bench for bg_tile_renderer with behavioural
// synchronous tile-map RAM and sprite-sheet ROM (one read register each).
module tb_bg_tile_renderer;

   logic        clk;
   logic        reset;
   logic        video_on;
   logic [9:0]  x;
   logic [9:0]  y;
   logic [3:0]  bg_x_offset;
   logic        hsync_in;
   logic        vsync_in;
   logic [11:0] rgb;
   logic        hsync_out;
   logic        vsync_out;
   logic        pix_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] map   [0:2047];
   logic [11:0] sheet [0:16383];

   bg_tile_renderer_if mem_if ();

   bg_tile_renderer dut (
      .clk         (clk),
      .reset       (reset),
      .video_on    (video_on),
      .x           (x),
      .y           (y),
      .bg_x_offset (bg_x_offset),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .mem         (mem_if.master),
      .rgb         (rgb),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .pix_valid   (pix_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_if.bg_ram_data <= map[mem_if.bg_ram_addr[10:0]];
      mem_if.sheet_data  <= sheet[mem_if.sheet_addr];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic [3:0] off,
                        input logic von, input logic hs, input logic vs);
      x           = px;
      y           = py;
      bg_x_offset = off;
      video_on    = von;
      hsync_in    = hs;
      vsync_in    = vs;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(10'd100, 10'd50, 4'd0, 1'b0, 1'b1, 1'b1);
      steps(2);
      n_checks++; if (mem_if.bg_ram_addr !== 16'd0) begin n_fail++; $display("FAIL reset_bg_ram_addr: got %h expected 0000", mem_if.bg_ram_addr); end
      n_checks++; if (mem_if.sheet_addr !== 14'd0) begin n_fail++; $display("FAIL reset_sheet_addr: got %h expected 0000", mem_if.sheet_addr); end
      n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
      n_checks++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_hsync_out: got %b expected 1", hsync_out); end
      n_checks++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL reset_vsync_out: got %b expected 1", vsync_out); end
      #2 reset = 1'b0;
      steps(5);
   endtask

   // Idle on tile 126 (blank attr, px=4, py=2) then present pixel (0,0) on tile 9'h130.
   task automatic test_first_pixel();
      map[0]         = {23'h7FFFFF, 9'h130};
      sheet[14'h3000] = 12'h123;
      drive(10'd0, 10'd0, 4'd0, 1'b1, 1'b1, 1'b1);
      step();
      n_checks++; if (mem_if.bg_ram_addr !== 16'd0) begin n_fail++; $display("FAIL first_bg_ram_addr: got %0d expected 0", mem_if.bg_ram_addr); end
      step();
      n_checks++; if (mem_if.sheet_addr !== 14'h0104) begin n_fail++; $display("FAIL first_sheet_addr_n1: got %h expected 0104", mem_if.sheet_addr); end
      step();
      n_checks++; if (mem_if.sheet_addr !== 14'h3000) begin n_fail++; $display("FAIL first_sheet_addr_n2: got %h expected 3000", mem_if.sheet_addr); end
      step();
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL first_pix_valid_n3: got %b expected 0", pix_valid); end
      n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL first_rgb_n3: got %h expected 000", rgb); end
      step();
      n_checks++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL first_pix_valid_n4: got %b expected 1", pix_valid); end
      n_checks++; if (rgb !== 12'h123) begin n_fail++; $display("FAIL first_rgb_n4: got %h expected 123", rgb); end
   endtask

   task automatic test_address();
      drive(10'd639, 10'd479, 4'd0, 1'b1, 1'b1, 1'b1);
      step();
      n_checks++; if (mem_if.bg_ram_addr !== 16'd1199) begin n_fail++; $display("FAIL addr_last_tile: got %0d expected 1199", mem_if.bg_ram_addr); end
      drive(10'd0, 10'd480, 4'd0, 1'b1, 1'b1, 1'b1);
      step();
      n_checks++; if (mem_if.bg_ram_addr !== 16'd0) begin n_fail++; $display("FAIL addr_y_out_of_range: got %0d expected 0", mem_if.bg_ram_addr); end
      steps(4);
      n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL rgb_y_out_of_range: got %h expected 000", rgb); end
      n_checks++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL pix_valid_y_out_of_range: got %b expected 1", pix_valid); end
      drive(10'd100, 10'd50, 4'd5, 1'b1, 1'b1, 1'b1);
      step();
      n_checks++; if (mem_if.bg_ram_addr !== 16'd126) begin n_fail++; $display("FAIL addr_scrolled: got %0d expected 126", mem_if.bg_ram_addr); end
      drive(10'd639, 10'd0, 4'd15, 1'b1, 1'b1, 1'b1);
      step();
      n_checks++; if (mem_if.bg_ram_addr !== 16'd0) begin n_fail++; $display("FAIL addr_col_wrap: got %0d expected 0", mem_if.bg_ram_addr); end
      steps(2);
      n_checks++; if (mem_if.sheet_addr !== 14'h300E) begin n_fail++; $display("FAIL sheet_addr_col_wrap_px14: got %h expected 300e", mem_if.sheet_addr); end
   endtask

   task automatic test_flips();
      map[42]     = 32'h0000_01CA;
      sheet[3372] = 12'hABC;
      map[125]    = 32'h0000_0155;
      drive(10'd35, 10'd21, 4'd0, 1'b1, 1'b1, 1'b1);
      step();
      n_checks++; if (mem_if.bg_ram_addr !== 16'd42) begin n_fail++; $display("FAIL flip_xy_addr: got %0d expected 42", mem_if.bg_ram_addr); end
      steps(2);
      n_checks++; if (mem_if.sheet_addr !== 14'd3372) begin n_fail++; $display("FAIL flip_xy_sheet_addr: got %0d expected 3372", mem_if.sheet_addr); end
      steps(2);
      n_checks++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL flip_xy_rgb: got %h expected abc", rgb); end
      drive(10'd87, 10'd50, 4'd0, 1'b1, 1'b1, 1'b1);
      step();
      n_checks++; if (mem_if.bg_ram_addr !== 16'd125) begin n_fail++; $display("FAIL flip_x_addr: got %0d expected 125", mem_if.bg_ram_addr); end
      steps(2);
      n_checks++; if (mem_if.sheet_addr !== 14'h1158) begin n_fail++; $display("FAIL flip_x_sheet_addr: got %h expected 1158", mem_if.sheet_addr); end
   endtask

   task automatic test_colour_rules();
      map[43]  = 32'h0000_00CA;
      map[44]  = 32'h0000_0100;
      sheet[0] = 12'hF0F;
      drive(10'd48, 10'd16, 4'd0, 1'b1, 1'b1, 1'b1);
      steps(5);
      n_checks++; if (rgb !== 12'h6BF) begin n_fail++; $display("FAIL colour_disabled: got %h expected 6bf", rgb); end
      n_checks++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL colour_disabled_valid: got %b expected 1", pix_valid); end
      drive(10'd64, 10'd16, 4'd0, 1'b1, 1'b1, 1'b1);
      steps(5);
      n_checks++; if (rgb !== 12'h6BF) begin n_fail++; $display("FAIL colour_transparent: got %h expected 6bf", rgb); end
      drive(10'd35, 10'd21, 4'd0, 1'b0, 1'b1, 1'b1);
      steps(5);
      n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL colour_blanked: got %h expected 000", rgb); end
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL colour_blanked_valid: got %b expected 0", pix_valid); end
   endtask

   // Stream x=0..19 across tile 0 (attr 9'h100): sheet[px] = px, sheet[0] transparent.
   task automatic test_back_to_back();
      logic [11:0] exp_rgb;
      map[0] = 32'h0000_0100;
      drive(10'd0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      steps(5);
      for (int k = 0; k < 20; k++) begin
         drive(10'(k), 10'd0, 4'd0, 1'b1, 1'b1, 1'b1);
         step();
         if (k < 4)       exp_rgb = 12'h000;
         else if (k == 4) exp_rgb = 12'h6BF;
         else             exp_rgb = 12'(k - 4);
         n_checks++; if (rgb !== exp_rgb) begin n_fail++; $display("FAIL b2b_rgb[%0d]: got %h expected %h", k, rgb, exp_rgb); end
         n_checks++; if (pix_valid !== (k >= 4)) begin n_fail++; $display("FAIL b2b_pix_valid[%0d]: got %b expected %b", k, pix_valid, k >= 4); end
      end
   endtask

   task automatic test_sync();
      logic hs_q [0:139];
      logic vs_q [0:139];
      logic vo_q [0:139];
      logic exp_hs, exp_vs, exp_pv;
      int   h_low, v_low, h_first, v_first;
      h_low = 0; v_low = 0; h_first = -1; v_first = -1;
      drive(10'd0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      steps(5);
      for (int k = 0; k < 140; k++) begin
         hs_q[k] = !(k >= 10 && k < 106);
         vs_q[k] = !(k >= 20 && k < 23);
         vo_q[k] = (k % 3 != 0);
         drive(10'(k), 10'd0, 4'd0, vo_q[k], hs_q[k], vs_q[k]);
         step();
         exp_hs = (k >= 4) ? hs_q[k-4] : 1'b1;
         exp_vs = (k >= 4) ? vs_q[k-4] : 1'b1;
         exp_pv = (k >= 4) ? vo_q[k-4] : 1'b0;
         n_checks++; if (hsync_out !== exp_hs) begin n_fail++; $display("FAIL sync_hsync_out[%0d]: got %b expected %b", k, hsync_out, exp_hs); end
         n_checks++; if (vsync_out !== exp_vs) begin n_fail++; $display("FAIL sync_vsync_out[%0d]: got %b expected %b", k, vsync_out, exp_vs); end
         n_checks++; if (pix_valid !== exp_pv) begin n_fail++; $display("FAIL sync_pix_valid[%0d]: got %b expected %b", k, pix_valid, exp_pv); end
         if (hsync_out === 1'b0) begin h_low++; if (h_first < 0) h_first = k; end
         if (vsync_out === 1'b0) begin v_low++; if (v_first < 0) v_first = k; end
      end
      n_checks++; if (h_low != 96) begin n_fail++; $display("FAIL hsync_low_width: got %0d expected 96", h_low); end
      n_checks++; if (h_first != 14) begin n_fail++; $display("FAIL hsync_low_start: got %0d expected 14", h_first); end
      n_checks++; if (v_low != 3) begin n_fail++; $display("FAIL vsync_low_width: got %0d expected 3", v_low); end
      n_checks++; if (v_first != 24) begin n_fail++; $display("FAIL vsync_low_start: got %0d expected 24", v_first); end
   endtask

   task automatic test_reset_mid();
      drive(10'd35, 10'd21, 4'd0, 1'b1, 1'b0, 1'b0);
      steps(5);
      n_checks++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL pre_reset_rgb: got %h expected abc", rgb); end
      n_checks++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL pre_reset_hsync: got %b expected 0", hsync_out); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL async_reset_rgb: got %h expected 000", rgb); end
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_pix_valid: got %b expected 0", pix_valid); end
      n_checks++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL async_reset_hsync: got %b expected 1", hsync_out); end
      n_checks++; if (vsync_out !== 1'b1) begin n_fail++; $display("FAIL async_reset_vsync: got %b expected 1", vsync_out); end
      n_checks++; if (mem_if.bg_ram_addr !== 16'd0) begin n_fail++; $display("FAIL async_reset_bg_ram_addr: got %0d expected 0", mem_if.bg_ram_addr); end
      n_checks++; if (mem_if.sheet_addr !== 14'd0) begin n_fail++; $display("FAIL async_reset_sheet_addr: got %0d expected 0", mem_if.sheet_addr); end
      #2 reset = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         step();
         n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL post_reset_rgb[%0d]: got %h expected 000", e, rgb); end
         n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_pix_valid[%0d]: got %b expected 0", e, pix_valid); end
         n_checks++; if (hsync_out !== 1'b1) begin n_fail++; $display("FAIL post_reset_hsync[%0d]: got %b expected 1", e, hsync_out); end
      end
      steps(2);
      n_checks++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL post_reset_first_rgb: got %h expected abc", rgb); end
      n_checks++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_first_valid: got %b expected 1", pix_valid); end
      n_checks++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL post_reset_first_hsync: got %b expected 0", hsync_out); end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) map[i] = 32'h0;
      for (int i = 0; i < 16384; i++) sheet[i] = i[11:0];
      test_reset();
      test_first_pixel();
      test_address();
      test_flips();
      test_colour_rules();
      test_back_to_back();
      test_sync();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
